// File: rtl/operand_fetch_if.sv
// Decode-to-fetch request and fetch-to-execute operand handshake bundle
// for the operand_fetch stage. The master side drives requests and
// consumes operands; the slave side is the operand_fetch stage itself.
interface operand_fetch_if #(
    parameter int XLEN = 64
);
    logic            req_valid;
    logic            req_ready;
    logic [4:0]      req_rs1;
    logic [4:0]      req_rs2;
    logic [4:0]      req_rd;
    logic            req_rd_en;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_rs1_data;
    logic [XLEN-1:0] out_rs2_data;
    logic [4:0]      out_rd;
    logic            out_rd_en;

    modport master (
        output req_valid, req_rs1, req_rs2, req_rd, req_rd_en,
        input  req_ready,
        input  out_valid, out_rs1_data, out_rs2_data, out_rd, out_rd_en,
        output out_ready
    );

    modport slave (
        input  req_valid, req_rs1, req_rs2, req_rd, req_rd_en,
        output req_ready,
        output out_valid, out_rs1_data, out_rs2_data, out_rd, out_rd_en,
        input  out_ready
    );
endinterface

// File: rtl/operand_fetch.sv
// operand_fetch: issue-side operand read and register scoreboard.
// Reads both sources from the register file, stalls on pending writers
// (source or destination busy), passes writeback results through to the
// register file write port and holds the fetched bundle in a one-deep
// registered output stage.
// Optional feature: define OPFETCH_FWD_EN to forward a same-cycle
// writeback into the captured operands instead of stalling through it.
module operand_fetch #(
    parameter int XLEN = 64,
    parameter int NREG = 32
) (
    input  logic                clk,
    input  logic                rst,
    operand_fetch_if.slave      bus,
    output logic [4:0]          rf_rs1_addr,
    output logic [4:0]          rf_rs2_addr,
    input  logic [XLEN-1:0]     rf_rs1_data,
    input  logic [XLEN-1:0]     rf_rs2_data,
    output logic [4:0]          rf_wr_addr,
    output logic [XLEN-1:0]     rf_wr_data,
    output logic                rf_wr_en,
    input  logic                wb_valid,
    input  logic [4:0]          wb_rd,
    input  logic [XLEN-1:0]     wb_data,
    output logic [31:0]         perf_stall_cnt
);

`ifdef OPFETCH_FWD_EN
    localparam logic FWD_ON_C = 1'b1;
`else
    localparam logic FWD_ON_C = 1'b0;
`endif

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } ostate_t;

    ostate_t         state_r;
    logic            out_valid_r;
    logic [XLEN-1:0] out_rs1_data_r;
    logic [XLEN-1:0] out_rs2_data_r;
    logic [4:0]      out_rd_r;
    logic            out_rd_en_r;
    logic [NREG-1:0] busy_r;
    logic [31:0]     stall_cnt_r;

    logic            fwd_rs1_s;
    logic            fwd_rs2_s;
    logic            haz_rs1_s;
    logic            haz_rs2_s;
    logic            haz_rd_s;
    logic            wb_clr_rd_s;
    logic            any_hazard_s;
    logic            req_ready_s;
    logic            accept_s;
    logic            wr_en_s;
    logic [XLEN-1:0] op1_s;
    logic [XLEN-1:0] op2_s;
    logic [NREG-1:0] clr_mask_s;
    logic [NREG-1:0] set_mask_s;
    logic [NREG-1:0] busy_next_s;

    // Register file port pass-through: reads follow the request, writes follow writeback.
    assign rf_rs1_addr = bus.req_rs1;
    assign rf_rs2_addr = bus.req_rs2;
    assign rf_wr_addr  = wb_rd;
    assign rf_wr_data  = wb_data;
    assign rf_wr_en    = wr_en_s;

    assign bus.req_ready    = req_ready_s;
    assign bus.out_valid    = out_valid_r;
    assign bus.out_rs1_data = out_rs1_data_r;
    assign bus.out_rs2_data = out_rs2_data_r;
    assign bus.out_rd       = out_rd_r;
    assign bus.out_rd_en    = out_rd_en_r;
    assign perf_stall_cnt   = stall_cnt_r;

    // Hazard detection, forwarding selection and accept decision for the current request.
    always_comb begin
        wr_en_s      = wb_valid && (wb_rd != 5'd0);
        fwd_rs1_s    = FWD_ON_C && wb_valid && (wb_rd == bus.req_rs1) && (bus.req_rs1 != 5'd0);
        fwd_rs2_s    = FWD_ON_C && wb_valid && (wb_rd == bus.req_rs2) && (bus.req_rs2 != 5'd0);
        haz_rs1_s    = (bus.req_rs1 != 5'd0) && busy_r[bus.req_rs1] && !fwd_rs1_s;
        haz_rs2_s    = (bus.req_rs2 != 5'd0) && busy_r[bus.req_rs2] && !fwd_rs2_s;
        wb_clr_rd_s  = wb_valid && (wb_rd == bus.req_rd);
        haz_rd_s     = bus.req_rd_en && (bus.req_rd != 5'd0) && busy_r[bus.req_rd] && !wb_clr_rd_s;
        any_hazard_s = haz_rs1_s || haz_rs2_s || haz_rd_s;
        req_ready_s  = !rst && (!out_valid_r || bus.out_ready) && !any_hazard_s;
        accept_s     = bus.req_valid && req_ready_s;
        op1_s        = (bus.req_rs1 == 5'd0) ? {XLEN{1'b0}} :
                       (fwd_rs1_s ? wb_data : rf_rs1_data);
        op2_s        = (bus.req_rs2 == 5'd0) ? {XLEN{1'b0}} :
                       (fwd_rs2_s ? wb_data : rf_rs2_data);
    end

    // Next scoreboard value: writeback clears, accepted writer sets, set wins on collision.
    always_comb begin
        clr_mask_s  = wr_en_s ? ({{(NREG-1){1'b0}}, 1'b1} << wb_rd) : {NREG{1'b0}};
        set_mask_s  = (accept_s && bus.req_rd_en && (bus.req_rd != 5'd0)) ?
                      ({{(NREG-1){1'b0}}, 1'b1} << bus.req_rd) : {NREG{1'b0}};
        busy_next_s = (busy_r & ~clr_mask_s) | set_mask_s;
    end

    // Output stage FSM: EMPTY/FULL with registered bundle fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_EMPTY;
            out_valid_r    <= 1'b0;
            out_rs1_data_r <= {XLEN{1'b0}};
            out_rs2_data_r <= {XLEN{1'b0}};
            out_rd_r       <= 5'd0;
            out_rd_en_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_r        <= ST_FULL;
                        out_valid_r    <= 1'b1;
                        out_rs1_data_r <= op1_s;
                        out_rs2_data_r <= op2_s;
                        out_rd_r       <= bus.req_rd;
                        out_rd_en_r    <= bus.req_rd_en;
                    end else begin
                        state_r     <= ST_EMPTY;
                        out_valid_r <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (accept_s) begin
                        state_r        <= ST_FULL;
                        out_valid_r    <= 1'b1;
                        out_rs1_data_r <= op1_s;
                        out_rs2_data_r <= op2_s;
                        out_rd_r       <= bus.req_rd;
                        out_rd_en_r    <= bus.req_rd_en;
                    end else if (bus.out_ready) begin
                        state_r     <= ST_EMPTY;
                        out_valid_r <= 1'b0;
                    end else begin
                        state_r     <= ST_FULL;
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_EMPTY;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Scoreboard register; reset drops every pending writer.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= {NREG{1'b0}};
        end else begin
            busy_r <= busy_next_s;
        end
    end

    // Saturating count of cycles a presented request is held back by a hazard.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= 32'd0;
        end else if (bus.req_valid && any_hazard_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with an operand-bundle scoreboard and a
// behavioural register file attached to the read/write ports.
module tb_operand_fetch;

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic [4:0]  rd;
        logic        en;
    } bundle_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  rf_rs1_addr;
    logic [4:0]  rf_rs2_addr;
    logic [63:0] rf_rs1_data;
    logic [63:0] rf_rs2_data;
    logic [4:0]  rf_wr_addr;
    logic [63:0] rf_wr_data;
    logic        rf_wr_en;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = 5'd0;
    logic [63:0] wb_data = 64'd0;
    logic [31:0] perf_stall_cnt;

    logic [63:0] rf_mem [32];
    bundle_t     sb[$];
    int          n_total = 0;
    int          n_pass  = 0;
    int          n_fail  = 0;

    operand_fetch_if #(.XLEN(64)) bus ();

    operand_fetch #(.XLEN(64), .NREG(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .rf_rs1_addr    (rf_rs1_addr),
        .rf_rs2_addr    (rf_rs2_addr),
        .rf_rs1_data    (rf_rs1_data),
        .rf_rs2_data    (rf_rs2_data),
        .rf_wr_addr     (rf_wr_addr),
        .rf_wr_data     (rf_wr_data),
        .rf_wr_en       (rf_wr_en),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .perf_stall_cnt (perf_stall_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural register file: combinational read, r0 reads zero.
    always @(posedge clk) begin
        if (rf_wr_en) rf_mem[rf_wr_addr] <= rf_wr_data;
    end
    assign rf_rs1_data = (rf_rs1_addr == 5'd0) ? 64'd0 : rf_mem[rf_rs1_addr];
    assign rf_rs2_data = (rf_rs2_addr == 5'd0) ? 64'd0 : rf_mem[rf_rs2_addr];

    function automatic logic [63:0] val(input int i);
        case (i)
            3:       val = 64'h11;
            4:       val = 64'h22;
            default: val = 64'h1000 + 64'(i);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs after the falling edge, check, then cross the rising edge.
    task automatic step(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic en, input logic ordy,
                        input logic wbv, input logic [4:0] wbrd, input logic [63:0] wbd,
                        input logic exp_rdy, input logic [63:0] e1, input logic [63:0] e2,
                        input string tag);
        bundle_t f;
        bus.req_valid = v;
        bus.req_rs1   = rs1;
        bus.req_rs2   = rs2;
        bus.req_rd    = rd;
        bus.req_rd_en = en;
        bus.out_ready = ordy;
        wb_valid      = wbv;
        wb_rd         = wbrd;
        wb_data       = wbd;
        #1;
        chk({tag, ":req_ready"}, 64'(bus.req_ready), 64'(exp_rdy));
        chk({tag, ":rf_rs1_addr"}, 64'(rf_rs1_addr), 64'(rs1));
        chk({tag, ":rf_rs2_addr"}, 64'(rf_rs2_addr), 64'(rs2));
        chk({tag, ":rf_wr_en"}, 64'(rf_wr_en), 64'(wbv && (wbrd != 5'd0)));
        if (wbv) begin
            chk({tag, ":rf_wr_addr"}, 64'(rf_wr_addr), 64'(wbrd));
            chk({tag, ":rf_wr_data"}, rf_wr_data, wbd);
        end
        chk({tag, ":out_valid"}, 64'(bus.out_valid), 64'(sb.size() != 0));
        if (sb.size() != 0) begin
            f = sb[0];
            chk({tag, ":out_rs1_data"}, bus.out_rs1_data, f.a);
            chk({tag, ":out_rs2_data"}, bus.out_rs2_data, f.b);
            chk({tag, ":out_rd"}, 64'(bus.out_rd), 64'(f.rd));
            chk({tag, ":out_rd_en"}, 64'(bus.out_rd_en), 64'(f.en));
            if (ordy) void'(sb.pop_front());
        end
        if (v && exp_rdy) begin
            f.a  = e1;
            f.b  = e2;
            f.rd = rd;
            f.en = en;
            sb.push_back(f);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic iss(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic en, input logic ordy, input logic exp_rdy,
                       input logic [63:0] e1, input logic [63:0] e2, input string tag);
        step(1'b1, rs1, rs2, rd, en, ordy, 1'b0, 5'd0, 64'd0, exp_rdy, e1, e2, tag);
    endtask

    task automatic wbk(input logic [4:0] rd, input logic [63:0] d, input string tag);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, rd, d, 1'b1, 64'd0, 64'd0, tag);
    endtask

    task automatic idle(input string tag);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 64'd0, 1'b1, 64'd0, 64'd0, tag);
    endtask

    initial begin
        bus.req_valid = 1'b1;
        bus.req_rs1   = 5'd0;
        bus.req_rs2   = 5'd0;
        bus.req_rd    = 5'd0;
        bus.req_rd_en = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst:req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst:out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst:out_rs1_data", bus.out_rs1_data, 64'd0);
        chk("rst:out_rs2_data", bus.out_rs2_data, 64'd0);
        chk("rst:out_rd", 64'(bus.out_rd), 64'd0);
        chk("rst:out_rd_en", 64'(bus.out_rd_en), 64'd0);
        chk("rst:perf", 64'(perf_stall_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Load register file through the writeback pass-through
        for (int i = 1; i < 32; i++) wbk(5'(i), val(i), "init");

        // Basic issue and busy marking of rd=5
        iss(5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 1'b1, 64'h11, 64'h22, "t1_issue");
        iss(5'd5, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 64'd0, 64'd0, "t1_probe_r5");
        chk("t1:perf", 64'(perf_stall_cnt), 64'd1);
        wbk(5'd5, val(5), "t1_clr5");

        // Producer rd=5, consumer rs1=5, writeback two cycles later
        iss(5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, 64'd0, 64'd0, "t2_prod");
        iss(5'd5, 5'd4, 5'd6, 1'b1, 1'b1, 1'b0, 64'd0, 64'd0, "t2_stall1");
        iss(5'd5, 5'd4, 5'd6, 1'b1, 1'b1, 1'b0, 64'd0, 64'd0, "t2_stall2");
`ifdef OPFETCH_FWD_EN
        step(1'b1, 5'd5, 5'd4, 5'd6, 1'b1, 1'b1, 1'b1, 5'd5, 64'hABCD, 1'b1,
             64'hABCD, 64'h22, "t2_fwd");
        idle("t2_drain");
        chk("t2:perf", 64'(perf_stall_cnt), 64'd3);
`else
        step(1'b1, 5'd5, 5'd4, 5'd6, 1'b1, 1'b1, 1'b1, 5'd5, 64'hABCD, 1'b0,
             64'd0, 64'd0, "t2_wbcyc");
        iss(5'd5, 5'd4, 5'd6, 1'b1, 1'b1, 1'b1, 64'hABCD, 64'h22, "t2_late");
        idle("t2_drain");
        chk("t2:perf", 64'(perf_stall_cnt), 64'd4);
`endif
        wbk(5'd6, val(6), "t2_clr6");

        // All registers busy except r0; r0-only request must still issue
        for (int i = 1; i < 32; i++) iss(5'd0, 5'd0, 5'(i), 1'b1, 1'b1, 1'b1, 64'd0, 64'd0, "t3_fill");
        iss(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 64'd0, 64'd0, "t3_r0");
        iss(5'd3, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 64'd0, 64'd0, "t3_busy3");
        wbk(5'd0, 64'hDEAD, "t3_wb_r0");
        for (int i = 1; i < 32; i++) wbk(5'(i), val(i), "t3_clr");

        // Backpressure: hold for 5 cycles, then back-to-back accept
        iss(5'd3, 5'd4, 5'd8, 1'b1, 1'b0, 1'b1, 64'h11, 64'h22, "t4_first");
        for (int i = 0; i < 5; i++) iss(5'd7, 5'd9, 5'd10, 1'b1, 1'b0, 1'b0, 64'd0, 64'd0, "t4_hold");
        iss(5'd7, 5'd9, 5'd10, 1'b1, 1'b1, 1'b1, val(7), val(9), "t4_b2b");
        idle("t4_drain");
`ifdef OPFETCH_FWD_EN
        chk("t4:perf", 64'(perf_stall_cnt), 64'd4);
`else
        chk("t4:perf", 64'(perf_stall_cnt), 64'd5);
`endif
        wbk(5'd8, val(8), "t4_clr8");
        wbk(5'd10, val(10), "t4_clr10");

        // Same-edge set and clear of r7: set wins
        iss(5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b1, 64'd0, 64'd0, "t5_w1");
        step(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, val(7), 1'b1,
             64'd0, 64'd0, "t5_w2");
        iss(5'd7, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 64'd0, 64'd0, "t5_rd7_stall");
`ifdef OPFETCH_FWD_EN
        step(1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd7, 64'h7777, 1'b1,
             64'h7777, 64'd0, "t5_fwd");
`else
        step(1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd7, 64'h7777, 1'b0,
             64'd0, 64'd0, "t5_wbcyc");
        iss(5'd7, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 64'h7777, 64'd0, "t5_late");
`endif
        idle("t5_drain");

        // Reset mid-operation with busy[9] and a held bundle
        iss(5'd3, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1, 64'h11, 64'd0, "t6_w9");
        rst = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_rs1   = 5'd0;
        bus.req_rd    = 5'd0;
        bus.req_rd_en = 1'b0;
        #1;
        chk("t6:out_valid_pre", 64'(bus.out_valid), 64'd1);
        chk("t6:req_ready_in_rst", 64'(bus.req_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        #1;
        chk("t6:out_valid", 64'(bus.out_valid), 64'd0);
        chk("t6:out_rs1_data", bus.out_rs1_data, 64'd0);
        chk("t6:out_rd", 64'(bus.out_rd), 64'd0);
        chk("t6:perf", 64'(perf_stall_cnt), 64'd0);
        iss(5'd9, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, val(9), 64'd0, "t6_rd9");
        wbk(5'd9, 64'h9999, "t6_wb9");
        iss(5'd9, 5'd3, 5'd0, 1'b0, 1'b1, 1'b1, 64'h9999, 64'h11, "t6_rd9_new");
        idle("t6_drain");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
